// File: rtl/id_stage_pkg.sv
// Shared decode-stage definitions: opcodes, instruction field positions and FSM states.
package id_stage_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int OP_W       = 6;
    localparam int OP_LSB     = 26;
    localparam int RS1_LSB    = 21;
    localparam int RS2_LSB    = 16;
    localparam int RD_LSB     = 11;
    localparam int IMM_W      = 16;
    localparam int JT_W       = 26;

    localparam logic [OP_W-1:0] OP_ALU   = 6'd0;
    localparam logic [OP_W-1:0] OP_LOAD  = 6'd1;
    localparam logic [OP_W-1:0] OP_STORE = 6'd2;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd3;
    localparam logic [OP_W-1:0] OP_JMP   = 6'd4;

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Opcodes that actually read the rs2 register (LOAD reuses the field as its destination).
    function automatic logic uses_rs2(input logic [OP_W-1:0] op);
        return (op == OP_ALU) || (op == OP_STORE) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/id_hazard.sv
// Load-use hazard detector: flags an instruction that reads the register a load in EX is still producing.
module id_hazard
    import id_stage_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [OP_W-1:0]   op,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              last_load_valid,
    input  logic [REG_AW-1:0] last_load_rd,
    output logic              hazard
);

    always_comb begin
        hazard = 1'b0;
        if (last_load_valid && (last_load_rd != '0)) begin
            hazard = (rs1 == last_load_rd) || (uses_rs2(op) && (rs2 == last_load_rd));
        end
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: resolves BEQ/JMP, stalls fetch on load-use, squashes the wrong-path slot, registers operands for EX.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-3:0]    PC,
    input  logic [WIDTH-1:0]    IR,
    output logic                IsStall,
    output logic                IsBranch,
    output logic [WIDTH-3:0]    BranchAddr,
    output logic [REG_AW-1:0]   rs1_addr,
    output logic [REG_AW-1:0]   rs2_addr,
    input  logic [WIDTH-1:0]    rs1_data,
    input  logic [WIDTH-1:0]    rs2_data,
    output logic                ex_valid,
    output logic [WIDTH-3:0]    ex_pc,
    output logic [OP_W-1:0]     ex_op,
    output logic [REG_AW-1:0]   ex_rd,
    output logic [WIDTH-1:0]    ex_a,
    output logic [WIDTH-1:0]    ex_b,
    output logic [WIDTH-1:0]    ex_imm
);

    localparam int PW = WIDTH - 2;

    state_e              state_q, state_d;
    logic                last_load_valid_q, last_load_valid_d;
    logic [REG_AW-1:0]   last_load_rd_q, last_load_rd_d;
    logic                ex_valid_q, ex_valid_d;
    logic [PW-1:0]       ex_pc_q, ex_pc_d;
    logic [OP_W-1:0]     ex_op_q, ex_op_d;
    logic [REG_AW-1:0]   ex_rd_q, ex_rd_d;
    logic [WIDTH-1:0]    ex_a_q, ex_a_d;
    logic [WIDTH-1:0]    ex_b_q, ex_b_d;
    logic [WIDTH-1:0]    ex_imm_q, ex_imm_d;

    logic [OP_W-1:0]     op;
    logic [REG_AW-1:0]   rs1, rs2, rd;
    logic [IMM_W-1:0]    imm;
    logic [WIDTH-1:0]    imm_sext;
    logic [JT_W+1:0]     jmp_word;
    logic [PW-1:0]       beq_tgt, jmp_tgt;
    logic                hazard, run, issue, taken;

    assign op       = IR[OP_LSB +: OP_W];
    assign rs1      = IR[RS1_LSB +: REG_AW];
    assign rs2      = IR[RS2_LSB +: REG_AW];
    assign rd       = IR[RD_LSB +: REG_AW];
    assign imm      = IR[IMM_W-1:0];
    assign imm_sext = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
    assign rs1_addr = rs1;
    assign rs2_addr = rs2;

    id_hazard #(.REG_AW(REG_AW)) u_hazard (
        .op              (op),
        .rs1             (rs1),
        .rs2             (rs2),
        .last_load_valid (last_load_valid_q),
        .last_load_rd    (last_load_rd_q),
        .hazard          (hazard)
    );

    // Targets wrap silently modulo 2^PW.
    assign beq_tgt  = PC + {imm_sext[PW-3:0], 2'b00};
    assign jmp_word = {IR[JT_W-1:0], 2'b00};
    assign jmp_tgt  = PW'(jmp_word);

    assign run   = (state_q == ST_RUN);
    assign issue = run && !hazard;
    assign taken = (op == OP_JMP) || ((op == OP_BEQ) && (rs1_data == rs2_data));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_FLUSH;
        else     state_q <= state_d;
    end

    // Next state: a taken branch squashes the fall-through fetched alongside the redirect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FLUSH: state_d = ST_RUN;
            ST_RUN:   if (issue && taken) state_d = ST_FLUSH;
            default:  state_d = ST_FLUSH;
        endcase
    end

    // Fetch control outputs
    always_comb begin
        IsStall    = 1'b0;
        IsBranch   = 1'b0;
        BranchAddr = '0;
        if (!rst) begin
            IsStall  = run && hazard;
            IsBranch = issue && taken;
            if (IsBranch) BranchAddr = (op == OP_JMP) ? jmp_tgt : beq_tgt;
        end
    end

    always_comb begin
        ex_valid_d        = 1'b0;
        ex_pc_d           = ex_pc_q;
        ex_op_d           = ex_op_q;
        ex_rd_d           = ex_rd_q;
        ex_a_d            = ex_a_q;
        ex_b_d            = ex_b_q;
        ex_imm_d          = ex_imm_q;
        last_load_valid_d = 1'b0;
        last_load_rd_d    = last_load_rd_q;
        if (issue) begin
            ex_valid_d        = 1'b1;
            ex_pc_d           = PC;
            ex_op_d           = op;
            ex_rd_d           = (op == OP_LOAD) ? rs2 : rd;
            ex_a_d            = rs1_data;
            ex_b_d            = rs2_data;
            ex_imm_d          = imm_sext;
            last_load_valid_d = (op == OP_LOAD);
            last_load_rd_d    = rs2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q        <= 1'b0;
            ex_pc_q           <= '0;
            ex_op_q           <= '0;
            ex_rd_q           <= '0;
            ex_a_q            <= '0;
            ex_b_q            <= '0;
            ex_imm_q          <= '0;
            last_load_valid_q <= 1'b0;
            last_load_rd_q    <= '0;
        end else begin
            ex_valid_q        <= ex_valid_d;
            ex_pc_q           <= ex_pc_d;
            ex_op_q           <= ex_op_d;
            ex_rd_q           <= ex_rd_d;
            ex_a_q            <= ex_a_d;
            ex_b_q            <= ex_b_d;
            ex_imm_q          <= ex_imm_d;
            last_load_valid_q <= last_load_valid_d;
            last_load_rd_q    <= last_load_rd_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_pc    = ex_pc_q;
    assign ex_op    = ex_op_q;
    assign ex_rd    = ex_rd_q;
    assign ex_a     = ex_a_q;
    assign ex_b     = ex_b_q;
    assign ex_imm   = ex_imm_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: per-cycle vector table plus a reset-during-stall sequence.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] PC;
    logic [31:0] IR;
    logic        IsStall, IsBranch;
    logic [29:0] BranchAddr;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        ex_valid;
    logic [29:0] ex_pc;
    logic [5:0]  ex_op;
    logic [4:0]  ex_rd;
    logic [31:0] ex_a, ex_b, ex_imm;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_stage #(.WIDTH(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .PC(PC), .IR(IR),
        .IsStall(IsStall), .IsBranch(IsBranch), .BranchAddr(BranchAddr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op(ex_op), .ex_rd(ex_rd),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm)
    );

    typedef struct {
        logic        rst;
        logic [29:0] pc;
        logic [31:0] ir;
        logic [31:0] d1, d2;
        logic        e_stall, e_br;
        logic [29:0] e_ba;
        logic        e_vld;
        logic [4:0]  e_rd;
        logic [31:0] e_a, e_b, e_imm;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] f_alu(input int rd, input int r1, input int r2);
        return {6'd0, 5'(r1), 5'(r2), 5'(rd), 11'd0};
    endfunction
    function automatic logic [31:0] f_load(input int rt, input int r1, input logic [15:0] im);
        return {6'd1, 5'(r1), 5'(rt), im};
    endfunction
    function automatic logic [31:0] f_beq(input int r1, input int r2, input logic [15:0] im);
        return {6'd3, 5'(r1), 5'(r2), im};
    endfunction
    function automatic logic [31:0] f_jmp(input logic [25:0] t);
        return {6'd4, t};
    endfunction

    function automatic vec_t mk(input logic r, input logic [29:0] pc, input logic [31:0] ir,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic st, input logic br, input logic [29:0] ba,
                                input logic vld, input int rd, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] im);
        vec_t v;
        v.rst = r; v.pc = pc; v.ir = ir; v.d1 = d1; v.d2 = d2;
        v.e_stall = st; v.e_br = br; v.e_ba = ba; v.e_vld = vld;
        v.e_rd = 5'(rd); v.e_a = a; v.e_b = b; v.e_imm = im;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [29:0] pc, input logic [31:0] ir,
                         input logic [31:0] d1, input logic [31:0] d2);
        rst = r; PC = pc; IR = ir; rs1_data = d1; rs2_data = d2;
    endtask

    task automatic check_ex(input int idx, input vec_t v);
        check($sformatf("ex_valid[%0d]", idx), 32'(ex_valid), 32'(v.e_vld));
        if (v.e_vld || v.rst) begin
            check($sformatf("ex_pc[%0d]", idx), 32'(ex_pc), v.rst ? 32'd0 : 32'(v.pc));
            check($sformatf("ex_op[%0d]", idx), 32'(ex_op), v.rst ? 32'd0 : 32'(v.ir[31:26]));
            check($sformatf("ex_rd[%0d]", idx), 32'(ex_rd), 32'(v.e_rd));
            check($sformatf("ex_a[%0d]", idx), ex_a, v.e_a);
            check($sformatf("ex_b[%0d]", idx), ex_b, v.e_b);
            check($sformatf("ex_imm[%0d]", idx), ex_imm, v.e_imm);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        drive(v.rst, v.pc, v.ir, v.d1, v.d2);
        @(negedge clk);
        check($sformatf("IsStall[%0d]", idx), 32'(IsStall), 32'(v.e_stall));
        check($sformatf("IsBranch[%0d]", idx), 32'(IsBranch), 32'(v.e_br));
        check($sformatf("BranchAddr[%0d]", idx), 32'(BranchAddr), 32'(v.e_ba));
        check($sformatf("rs1_addr[%0d]", idx), 32'(rs1_addr), 32'(v.ir[25:21]));
        check($sformatf("rs2_addr[%0d]", idx), 32'(rs2_addr), 32'(v.ir[20:16]));
        @(posedge clk); #1;
        check_ex(idx, v);
    endtask

    initial begin
        vec_t z;
        drive(1'b1, '0, '0, '0, '0);
        @(posedge clk); #1;

        //            rst pc     ir                         d1   d2   st br ba          vld rd  a    b    imm
        tbl.push_back(mk(1, 30'h0,  32'hFC000000,            0,   0,  0, 0, 30'h0,       0, 0,  0,   0,   0));
        tbl.push_back(mk(0, 30'h10, f_alu(3,1,2),           11,  22,  0, 0, 30'h0,       0, 0,  0,   0,   0));
        tbl.push_back(mk(0, 30'h10, f_alu(3,1,2),           11,  22,  0, 0, 30'h0,       1, 3,  11,  22,  32'h1800));
        tbl.push_back(mk(0, 30'h14, f_load(5,1,16'h4),      100, 0,   0, 0, 30'h0,       1, 5,  100, 0,   4));
        tbl.push_back(mk(0, 30'h18, f_alu(6,5,2),           1,   2,   1, 0, 30'h0,       0, 0,  0,   0,   0));
        tbl.push_back(mk(0, 30'h18, f_alu(6,5,2),           55,  2,   0, 0, 30'h0,       1, 6,  55,  2,   32'h3000));
        tbl.push_back(mk(0, 30'h20, f_beq(1,2,16'hFFFE),    7,   7,   0, 1, 30'h18,      1, 31, 7,   7,   32'hFFFFFFFE));
        tbl.push_back(mk(0, 30'h24, f_alu(3,1,2),           1,   2,   0, 0, 30'h0,       0, 0,  0,   0,   0));
        tbl.push_back(mk(0, 30'h28, f_beq(1,2,16'h5),       7,   8,   0, 0, 30'h0,       1, 0,  7,   8,   5));
        tbl.push_back(mk(0, 30'h2C, f_alu(3,1,2),           1,   2,   0, 0, 30'h0,       1, 3,  1,   2,   32'h1800));
        tbl.push_back(mk(0, 30'h30, f_jmp(26'h40),          0,   0,   0, 1, 30'h100,     1, 0,  0,   0,   32'h40));
        tbl.push_back(mk(0, 30'h34, f_jmp(26'h80),          0,   0,   0, 0, 30'h0,       0, 0,  0,   0,   0));
        tbl.push_back(mk(0, 30'h38, f_alu(3,1,2),           9,   9,   0, 0, 30'h0,       1, 3,  9,   9,   32'h1800));
        tbl.push_back(mk(0, 30'h0,  f_beq(0,0,16'hFFFF),    0,   0,   0, 1, 30'h3FFFFFFC, 1, 31, 0,  0,   32'hFFFFFFFF));
        tbl.push_back(mk(0, 30'h3C, 32'hFC000000,           0,   0,   0, 0, 30'h0,       0, 0,  0,   0,   0));
        tbl.push_back(mk(0, 30'h40, f_load(0,2,16'h0),      3,   0,   0, 0, 30'h0,       1, 0,  3,   0,   0));
        tbl.push_back(mk(0, 30'h44, f_alu(7,0,0),           4,   4,   0, 0, 30'h0,       1, 7,  4,   4,   32'h3800));
        tbl.push_back(mk(0, 30'h48, f_load(5,1,16'h0),      6,   0,   0, 0, 30'h0,       1, 5,  6,   0,   0));
        tbl.push_back(mk(0, 30'h4C, f_load(5,1,16'h0),      6,   0,   0, 0, 30'h0,       1, 5,  6,   0,   0));
        tbl.push_back(mk(0, 30'h50, f_alu(1,2,5),           2,   9,   1, 0, 30'h0,       0, 0,  0,   0,   0));
        tbl.push_back(mk(0, 30'h50, f_alu(1,2,5),           2,   9,   0, 0, 30'h0,       1, 1,  2,   9,   32'h800));

        foreach (tbl[i]) run_vec(i, tbl[i]);

        // Reset arriving during a load-use stall on a would-be-taken BEQ.
        run_vec(100, mk(0, 30'h60, f_load(4,1,16'h0), 0, 0, 0, 0, 30'h0, 1, 4, 0, 0, 0));
        drive(1'b0, 30'h64, f_beq(1,4,16'hFFFE), 7, 7);
        @(negedge clk);
        check("mid_rst_stall_before", 32'(IsStall), 32'd1);
        check("mid_rst_branch_before", 32'(IsBranch), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_stall", 32'(IsStall), 32'd0);
        check("mid_rst_branch", 32'(IsBranch), 32'd0);
        check("mid_rst_baddr", 32'(BranchAddr), 32'd0);
        @(posedge clk); #1;
        z = mk(1, 30'h0, 32'hFC000000, 0, 0, 0, 0, 30'h0, 0, 0, 0, 0, 0);
        check_ex(101, z);
        // First post-reset cycle is a bubble; the retried BEQ then issues with no hazard left.
        run_vec(102, mk(0, 30'h64, f_beq(1,4,16'hFFFE), 7, 7, 0, 0, 30'h0, 0, 0, 0, 0, 0));
        run_vec(103, mk(0, 30'h64, f_beq(1,4,16'hFFFE), 7, 7, 0, 1, 30'h5C, 1, 31, 7, 7, 32'hFFFFFFFE));
        run_vec(104, mk(0, 30'h68, f_alu(3,1,2), 5, 6, 0, 0, 30'h0, 0, 0, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
